index_prefix_sequencer: RTL and testbench
=========================================

Name: index_prefix_sequencer

Overview:
- Sequences the IX/IY-prefixed instruction decoder.
- Owns the 5-bit XPT step counter and its complement, the prefix mode state (none / IX / IY / IX-CB / IY-CB) and the next-machine-cycle type flags.
- Drives the decoder's not_enable and is_Y. Consumes the decoder's PR_/P2_ control pulses and applies them on the next qualified step edge.
- Sits between the main opcode-fetch decoder and the XIX decoder.

Parameters:
- XPT_W, 5, width of the step counter.
- XPT_MAX, 31, terminal count; the counter saturates here and raises an error.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- not_reset  in  1  asynchronous, active-low reset.
- step_en  in  1  step qualifier; 0 means memory wait, and all state holds.
- prefix_dd  in  1  main decoder has fetched 0xDD.
- prefix_fd  in  1  main decoder has fetched 0xFD.
- PR_Reset_XPT  in  1  return XPT to 0.
- P2_Reset_XIX  in  1  end of IX-prefixed instruction.
- P2_Reset_XIY  in  1  end of IY-prefixed instruction.
- P2_Set_CM1  in  1  next cycle is an opcode fetch (M1).
- P2_Set_CMR  in  1  next cycle is a memory read.
- P2_Set_XIX4_0  in  1  enter DDCB sub-sequence.
- P2_Set_XIY4_0  in  1  enter FDCB sub-sequence.
- int_req  in  1  pending maskable interrupt.
- XPT  out  5  current step.
- notXPT  out  5  bitwise complement of XPT, registered, never decoded from XPT.
- xix_not_enable  out  1  0 only in state XIX or XIY.
- is_Y  out  1  1 in state XIY or XIYCB.
- cb_indexed  out  1  1 in state XIXCB or XIYCB.
- cycle_m1  out  1  M1 flag.
- cycle_mr  out  1  memory-read flag.
- int_accept  out  1  interrupt may be taken this step.
- seq_error  out  1  sticky fault flag.

Behaviour:
- Reset (not_reset=0, asynchronous):
  - State NONE, XPT=0, notXPT=5'b11111.
  - xix_not_enable=1, is_Y=0, cb_indexed=0.
  - cycle_m1=1 (the first cycle after reset is a fetch), cycle_mr=0, int_accept=0, seq_error=0.
  - Reset mid-instruction discards the prefix state.
- Update rule:
  - All inputs are sampled only on a rising edge with step_en=1.
  - With step_en=0 every register holds and int_accept reads 0.
- States and transitions:
  - States: NONE, XIX, XIY, XIXCB, XIYCB.
  - Priority within one step, highest first: prefix_dd/prefix_fd, then Set_XIx4_0, then Reset_XIx.
  - NONE -prefix_dd-> XIX. NONE -prefix_fd-> XIY. In both cases XPT is set to 0.
  - Any state -prefix_dd/fd-> XIX/XIY with XPT=0. A repeated prefix restarts the sequence and the last prefix wins.
  - prefix_dd and prefix_fd together: go to XIY and set seq_error.
  - XIX -P2_Set_XIX4_0-> XIXCB. XIY -P2_Set_XIY4_0-> XIYCB.
  - XIX or XIXCB -P2_Reset_XIX-> NONE. XIY or XIYCB -P2_Reset_XIY-> NONE.
  - Reset_XIX while in an IY state, or Reset_XIY while in an IX state: state holds, seq_error set.
  - In state NONE, any P2_Reset_*, P2_Set_XI*4_0 or PR_Reset_XPT is ignored, with no error.
- XPT counter:
  - Each qualified step: XPT <= 0 if PR_Reset_XPT or a prefix is taken; otherwise XPT+1.
  - At XPT_MAX it holds and seq_error is set.
  - notXPT is updated in the same edge.
- Cycle flags:
  - cycle_m1 and cycle_mr are valid for exactly one qualified step after the step that requested them, then clear.
  - Set_CM1 together with Set_CMR: cycle_m1=1, cycle_mr=0, seq_error set.
- Interrupt:
  - int_accept = int_req & cycle_m1 & state==NONE & step_en (combinational).
  - Interrupts are never accepted between a prefix and its opcode, or inside DDCB/FDCB.
- Latency: a decoder pulse at step n is visible on the outputs after the step n edge, i.e. at step n+1.

Decomposition:
- Shared package:
  - State encoding constants (NONE=3'd0, XIX=3'd1, XIY=3'd2, XIXCB=3'd5, XIYCB=3'd6). Bit0 indicates X, bit1 indicates Y, bit2 indicates CB, so is_Y and cb_indexed are single-bit decodes.
  - XPT_W and XPT_MAX.
- Sub-module: xpt_step_counter (saturating counter with sync clear, registered complement, overflow flag).
- The prefix state machine and cycle flags remain in the top module.

Test Plan:
- Reset release, step_en=1 → cycle_m1=1, XPT=0, notXPT=31, xix_not_enable=1. Next step cycle_m1=0, XPT=1.
- prefix_dd, then 3 steps, then PR_Reset_XPT+P2_Reset_XIX+P2_Set_CM1 → XPT 0,1,2,3 with is_Y=0 and xix_not_enable=0, then state NONE, XPT=0, cycle_m1=1.
- prefix_fd, P2_Set_XIY4_0, then P2_Reset_XIY → is_Y=1; cb_indexed 0→1→0; int_req=1 throughout gives int_accept=0 until the cycle_m1 step in NONE, where it is 1.
- prefix_dd then prefix_fd on consecutive steps → is_Y=1, XPT=0, seq_error=0. Both prefixes in one step → state XIY, seq_error=1.
- step_en=0 for 4 cycles mid-XIX with P2_Reset_XIX asserted → no state/XPT change. On step_en=1, state goes to NONE.
- In XIX, 32 steps with no reset → XPT saturates at 31, seq_error=1 sticky. Async not_reset pulse mid-step clears everything immediately.

Source files
------------

// File: rtl/index_prefix_sequencer_pkg.sv
// Shared definitions for the IX/IY prefix sequencer: state encoding,
// step counter geometry and small state-decode helpers.
package index_prefix_sequencer_pkg;

   // Width of the XPT step counter and its terminal count.
   localparam int                 XPT_W   = 5;
   localparam logic [XPT_W-1:0]   XPT_MAX = 5'd31;

   // Prefix mode encoding. Bit0 marks an IX mode, bit1 an IY mode and bit2
   // the CB-indexed sub-sequence, so the decoder flags are single-bit picks.
   typedef enum logic [2:0] {
      ST_NONE  = 3'd0,
      ST_XIX   = 3'd1,
      ST_XIY   = 3'd2,
      ST_XIXCB = 3'd5,
      ST_XIYCB = 3'd6
   } prefix_state_t;

   // True for XIX and XIXCB.
   function automatic logic is_x_state(input prefix_state_t s);
      return s[0];
   endfunction

   // True for XIY and XIYCB.
   function automatic logic is_y_state(input prefix_state_t s);
      return s[1];
   endfunction

   // True for the plain prefixed modes, where the XIX decoder is enabled.
   function automatic logic is_plain_prefix(input prefix_state_t s);
      return (s == ST_XIX) || (s == ST_XIY);
   endfunction

endpackage

// File: rtl/index_prefix_sequencer_xpt.sv
// XPT step counter: saturating up-counter with synchronous clear, a
// separately registered complement and an overflow indication.
module xpt_step_counter
   import index_prefix_sequencer_pkg::*;
(
   input  logic             clock,
   input  logic             not_reset,
   input  logic             step_en,
   input  logic             clear,
   output logic [XPT_W-1:0] count,
   output logic [XPT_W-1:0] count_n,
   output logic             overflow
);

   localparam logic [XPT_W-1:0] ONE = XPT_W'(1);

   logic [XPT_W-1:0] count_next;

   // Overflow fires when a qualified step tries to advance past the terminal count.
   assign overflow   = step_en & ~clear & (count == XPT_MAX);
   assign count_next = count + ONE;

   // Counter and complement are both flops so the decoder never sees an inverter glitch.
   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         count   <= '0;
         count_n <= '1;
      end else if (step_en) begin
         if (clear) begin
            count   <= '0;
            count_n <= '1;
         end else if (count != XPT_MAX) begin
            count   <= count_next;
            count_n <= ~count_next;
         end
      end
   end

endmodule

// File: rtl/index_prefix_sequencer.sv
// IX/IY prefix sequencer: tracks the prefix mode, steps the XPT counter,
// registers the next-cycle type flags and gates interrupt acceptance.
module index_prefix_sequencer
   import index_prefix_sequencer_pkg::*;
(
   input  logic             clock,
   input  logic             not_reset,
   input  logic             step_en,
   input  logic             prefix_dd,
   input  logic             prefix_fd,
   input  logic             PR_Reset_XPT,
   input  logic             P2_Reset_XIX,
   input  logic             P2_Reset_XIY,
   input  logic             P2_Set_CM1,
   input  logic             P2_Set_CMR,
   input  logic             P2_Set_XIX4_0,
   input  logic             P2_Set_XIY4_0,
   input  logic             int_req,
   output logic [XPT_W-1:0] XPT,
   output logic [XPT_W-1:0] notXPT,
   output logic             xix_not_enable,
   output logic             is_Y,
   output logic             cb_indexed,
   output logic             cycle_m1,
   output logic             cycle_mr,
   output logic             int_accept,
   output logic             seq_error
);

   prefix_state_t state;

   logic prefix_taken;
   logic dual_prefix;
   logic set_taken;
   logic reset_match;
   logic reset_mismatch;
   logic flag_conflict;
   logic xpt_clear;
   logic xpt_overflow;
   logic step_fault;

   // Work out this step's transition conditions and any fault it raises.
   always_comb begin
      prefix_taken   = prefix_dd | prefix_fd;
      dual_prefix    = prefix_dd & prefix_fd;
      set_taken      = 1'b0;
      reset_match    = 1'b0;
      reset_mismatch = 1'b0;
      if (!prefix_taken && (state != ST_NONE)) begin
         set_taken = ((state == ST_XIX) & P2_Set_XIX4_0) |
                     ((state == ST_XIY) & P2_Set_XIY4_0);
         if (!set_taken) begin
            reset_match    = (is_x_state(state) & P2_Reset_XIX) |
                             (is_y_state(state) & P2_Reset_XIY);
            reset_mismatch = (is_y_state(state) & P2_Reset_XIX) |
                             (is_x_state(state) & P2_Reset_XIY);
         end
      end
      flag_conflict = P2_Set_CM1 & P2_Set_CMR;
      xpt_clear     = prefix_taken | (PR_Reset_XPT & (state != ST_NONE));
      step_fault    = dual_prefix | reset_mismatch | flag_conflict | xpt_overflow;
   end

   xpt_step_counter u_xpt (
      .clock     (clock),
      .not_reset (not_reset),
      .step_en   (step_en),
      .clear     (xpt_clear),
      .count     (XPT),
      .count_n   (notXPT),
      .overflow  (xpt_overflow)
   );

   // Prefix mode machine, one-step cycle flags and the sticky fault flag.
   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         state     <= ST_NONE;
         cycle_m1  <= 1'b1;
         cycle_mr  <= 1'b0;
         seq_error <= 1'b0;
      end else if (step_en) begin
         cycle_m1 <= P2_Set_CM1;
         cycle_mr <= P2_Set_CMR & ~P2_Set_CM1;
         if (step_fault) begin
            seq_error <= 1'b1;
         end
         if (prefix_fd) begin
            state <= ST_XIY;
         end else if (prefix_dd) begin
            state <= ST_XIX;
         end else if (set_taken) begin
            state <= (state == ST_XIX) ? ST_XIXCB : ST_XIYCB;
         end else if (reset_match) begin
            state <= ST_NONE;
         end
      end
   end

   assign xix_not_enable = ~is_plain_prefix(state);
   assign is_Y           = is_y_state(state);
   assign cb_indexed     = state[2];
   assign int_accept     = int_req & cycle_m1 & (state == ST_NONE) & step_en & not_reset;

endmodule

// File: tb/tb_index_prefix_sequencer.sv
// Self-checking bench for index_prefix_sequencer: directed scenarios plus
// randomized steps compared against a mode-level reference model.
module tb_index_prefix_sequencer;

   logic       clock = 1'b0;
   logic       not_reset;
   logic       step_en, prefix_dd, prefix_fd, PR_Reset_XPT;
   logic       P2_Reset_XIX, P2_Reset_XIY, P2_Set_CM1, P2_Set_CMR;
   logic       P2_Set_XIX4_0, P2_Set_XIY4_0, int_req;
   logic [4:0] XPT, notXPT;
   logic       xix_not_enable, is_Y, cb_indexed, cycle_m1, cycle_mr;
   logic       int_accept, seq_error;

   typedef struct packed {
      logic en, dd, fd, prx, resx, resy, cm1, cmr, setx, sety, intr;
   } stim_t;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: which index register is active (0 none, 1 IX, 2 IY),
   // whether the CB sub-sequence is active, the step number and flags.
   int mWhich, mXpt;
   bit mCb, mM1, mMr, mErr;

   index_prefix_sequencer dut (
      .clock          (clock),
      .not_reset      (not_reset),
      .step_en        (step_en),
      .prefix_dd      (prefix_dd),
      .prefix_fd      (prefix_fd),
      .PR_Reset_XPT   (PR_Reset_XPT),
      .P2_Reset_XIX   (P2_Reset_XIX),
      .P2_Reset_XIY   (P2_Reset_XIY),
      .P2_Set_CM1     (P2_Set_CM1),
      .P2_Set_CMR     (P2_Set_CMR),
      .P2_Set_XIX4_0  (P2_Set_XIX4_0),
      .P2_Set_XIY4_0  (P2_Set_XIY4_0),
      .int_req        (int_req),
      .XPT            (XPT),
      .notXPT         (notXPT),
      .xix_not_enable (xix_not_enable),
      .is_Y           (is_Y),
      .cb_indexed     (cb_indexed),
      .cycle_m1       (cycle_m1),
      .cycle_mr       (cycle_mr),
      .int_accept     (int_accept),
      .seq_error      (seq_error)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic driveInputs(input stim_t s);
      step_en       = s.en;
      prefix_dd     = s.dd;
      prefix_fd     = s.fd;
      PR_Reset_XPT  = s.prx;
      P2_Reset_XIX  = s.resx;
      P2_Reset_XIY  = s.resy;
      P2_Set_CM1    = s.cm1;
      P2_Set_CMR    = s.cmr;
      P2_Set_XIX4_0 = s.setx;
      P2_Set_XIY4_0 = s.sety;
      int_req       = s.intr;
   endtask

   task automatic modelReset();
      mWhich = 0;
      mCb    = 0;
      mXpt   = 0;
      mM1    = 1;
      mMr    = 0;
      mErr   = 0;
   endtask

   task automatic modelStep(input stim_t s);
      bit err;
      bit wasActive;
      err       = 0;
      wasActive = (mWhich != 0);
      if (s.dd || s.fd) begin
         mWhich = s.fd ? 2 : 1;
         mCb    = 0;
         mXpt   = 0;
         if (s.dd && s.fd) err = 1;
      end else begin
         if (wasActive) begin
            if (!mCb && ((mWhich == 1 && s.setx) || (mWhich == 2 && s.sety))) begin
               mCb = 1;
            end else begin
               if ((s.resx && mWhich == 2) || (s.resy && mWhich == 1)) err = 1;
               if ((s.resx && mWhich == 1) || (s.resy && mWhich == 2)) begin
                  mWhich = 0;
                  mCb    = 0;
               end
            end
         end
         if (wasActive && s.prx) mXpt = 0;
         else if (mXpt == 31) err = 1;
         else mXpt = mXpt + 1;
      end
      mM1 = s.cm1;
      mMr = s.cmr && !s.cm1;
      if (s.cm1 && s.cmr) err = 1;
      if (err) mErr = 1;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".XPT"}, int'(XPT), mXpt);
      checkOutput({tag, ".notXPT"}, int'(notXPT), 31 - mXpt);
      checkOutput({tag, ".xne"}, int'(xix_not_enable), (mWhich != 0 && !mCb) ? 0 : 1);
      checkOutput({tag, ".isY"}, int'(is_Y), (mWhich == 2) ? 1 : 0);
      checkOutput({tag, ".cb"}, int'(cb_indexed), int'(mCb));
      checkOutput({tag, ".m1"}, int'(cycle_m1), int'(mM1));
      checkOutput({tag, ".mr"}, int'(cycle_mr), int'(mMr));
      checkOutput({tag, ".err"}, int'(seq_error), int'(mErr));
   endtask

   // One step: drive at the falling edge, check the interrupt gate, then
   // check the registered outputs just after the rising edge.
   task automatic applyStimulus(input string tag, input stim_t s);
      @(negedge clock);
      driveInputs(s);
      #1;
      checkOutput({tag, ".intAcc"}, int'(int_accept),
                  (s.intr && mM1 && mWhich == 0 && s.en) ? 1 : 0);
      @(posedge clock);
      #1;
      if (s.en) modelStep(s);
      checkState(tag);
   endtask

   task automatic doReset();
      @(negedge clock);
      driveInputs('0);
      not_reset = 1'b0;
      modelReset();
      #12;
      checkState("reset");
      checkOutput("reset.intAcc", int'(int_accept), 0);
      @(negedge clock);
      not_reset = 1'b1;
   endtask

   function automatic stim_t randomStim();
      stim_t s;
      int r;
      s      = '0;
      s.en   = ($urandom_range(0, 7) != 0);
      r      = $urandom_range(0, 15);
      s.dd   = (r == 0) || (r == 2);
      s.fd   = (r == 1) || (r == 2);
      s.prx  = ($urandom_range(0, 3) == 0);
      r      = $urandom_range(0, 5);
      s.resx = (r == 0);
      s.resy = (r == 1);
      r      = $urandom_range(0, 5);
      s.setx = (r == 0);
      s.sety = (r == 1);
      s.cm1  = ($urandom_range(0, 3) == 0);
      s.cmr  = ($urandom_range(0, 4) == 0);
      s.intr = 1'($urandom_range(0, 1));
      return s;
   endfunction

   initial begin
      stim_t s;
      not_reset = 1'b0;
      driveInputs('0);
      modelReset();

      // Reset release and first fetch step.
      doReset();
      s = '0; s.en = 1;
      applyStimulus("first", s);

      // IX sequence with XPT counting, then return to NONE with a fetch.
      s = '0; s.en = 1; s.dd = 1;
      applyStimulus("ddPrefix", s);
      s = '0; s.en = 1;
      for (int i = 0; i < 3; i++) applyStimulus("ixCount", s);
      s = '0; s.en = 1; s.prx = 1; s.resx = 1; s.cm1 = 1;
      applyStimulus("ixEnd", s);

      // FDCB sequence with an interrupt pending throughout.
      s = '0; s.en = 1; s.fd = 1; s.intr = 1;
      applyStimulus("fdPrefix", s);
      s = '0; s.en = 1; s.sety = 1; s.intr = 1;
      applyStimulus("fdcbEnter", s);
      s = '0; s.en = 1; s.intr = 1;
      applyStimulus("fdcbStep", s);
      s = '0; s.en = 1; s.resy = 1; s.cm1 = 1; s.intr = 1;
      applyStimulus("fdcbEnd", s);
      s = '0; s.en = 1; s.intr = 1;
      applyStimulus("intWindow", s);

      // Back-to-back prefixes, then both in one step.
      s = '0; s.en = 1; s.dd = 1;
      applyStimulus("ddThenFd1", s);
      s = '0; s.en = 1; s.fd = 1;
      applyStimulus("ddThenFd2", s);
      s = '0; s.en = 1; s.dd = 1; s.fd = 1;
      applyStimulus("dualPrefix", s);

      // Memory wait while an end-of-instruction pulse is held.
      doReset();
      s = '0; s.en = 1; s.dd = 1;
      applyStimulus("waitPrefix", s);
      s = '0; s.resx = 1; s.intr = 1;
      for (int i = 0; i < 4; i++) applyStimulus("waitHold", s);
      s.en = 1;
      applyStimulus("waitRelease", s);

      // Saturation inside XIX, then an asynchronous reset in mid-step.
      s = '0; s.en = 1; s.dd = 1;
      applyStimulus("satPrefix", s);
      s = '0; s.en = 1;
      for (int i = 0; i < 33; i++) applyStimulus("satCount", s);
      checkOutput("satSticky", int'(seq_error), 1);
      #2;
      not_reset = 1'b0;
      modelReset();
      #1;
      checkState("asyncReset");
      @(negedge clock);
      not_reset = 1'b1;

      // Randomized steps, re-armed by reset periodically.
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) doReset();
         applyStimulus("rand", randomStim());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
